// File: rtl/ram_true_dp_param.sv
// rtl/ram_true_dp_param.sv - true dual-port byte-enabled RAM with per-port write modes and collision tracking
module ram_true_dp_param #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 10,
    parameter int WRITE_MODE = 0,
    parameter int OUT_REG    = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                weA,
    input  logic                weB,
    input  logic                reA,
    input  logic                reB,
    input  logic [DATA_W/8-1:0] beA,
    input  logic [DATA_W/8-1:0] beB,
    input  logic [ADDR_W-1:0]   addrA,
    input  logic [ADDR_W-1:0]   addrB,
    input  logic [DATA_W-1:0]   dinA,
    input  logic [DATA_W-1:0]   dinB,
    output logic [DATA_W-1:0]   doutA,
    output logic [DATA_W-1:0]   doutB,
    output logic                dvalidA,
    output logic                dvalidB,
    output logic                collision,
    output logic [15:0]         coll_cnt
);
    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] old_a, old_b;
    logic [DATA_W:0]   resp_a, resp_b;
    logic [NB-1:0]     lane_a, lane_b;
    logic              same_wr;
    logic [DATA_W-1:0] s1_a, s1_b;
    logic              s1_va, s1_vb;

    // Returns {valid, data} for one port given the word stored before this edge.
    function automatic logic [DATA_W:0] port_resp(
        input logic              we,
        input logic              re,
        input logic [NB-1:0]     be,
        input logic [DATA_W-1:0] din,
        input logic [DATA_W-1:0] old
    );
        logic [DATA_W-1:0] merged;
        merged = old;
        for (int k = 0; k < NB; k++) begin
            if (be[k]) merged[8*k +: 8] = din[8*k +: 8];
        end
        if (we) begin
            if (WRITE_MODE == 0)      return {1'b1, merged};
            else if (WRITE_MODE == 1) return {1'b1, old};
            else                      return {1'b0, old};
        end
        return {re, old};
    endfunction

    assign old_a   = mem[addrA];
    assign old_b   = mem[addrB];
    assign same_wr = weA && weB && (addrA == addrB);
    assign resp_a  = port_resp(weA, reA, beA, dinA, old_a);
    assign resp_b  = port_resp(weB, reB, beB, dinB, old_b);

    // Port A owns every lane it enables on a shared address; B fills only the rest.
    assign lane_a = weA ? beA : '0;
    assign lane_b = weB ? (beB & ~(same_wr ? beA : '0)) : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NB; k++) begin
                if (lane_a[k]) mem[addrA][8*k +: 8] <= dinA[8*k +: 8];
                if (lane_b[k]) mem[addrB][8*k +: 8] <= dinB[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_a  <= '0;
            s1_b  <= '0;
            s1_va <= 1'b0;
            s1_vb <= 1'b0;
        end else begin
            s1_va <= resp_a[DATA_W];
            s1_vb <= resp_b[DATA_W];
            if (resp_a[DATA_W]) s1_a <= resp_a[DATA_W-1:0];
            if (resp_b[DATA_W]) s1_b <= resp_b[DATA_W-1:0];
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] o_a, o_b;
            logic              o_va, o_vb;
            always_ff @(posedge clk) begin
                if (rst) begin
                    o_a  <= '0;
                    o_b  <= '0;
                    o_va <= 1'b0;
                    o_vb <= 1'b0;
                end else begin
                    o_va <= s1_va;
                    o_vb <= s1_vb;
                    if (s1_va) o_a <= s1_a;
                    if (s1_vb) o_b <= s1_b;
                end
            end
            assign doutA   = o_a;
            assign doutB   = o_b;
            assign dvalidA = o_va;
            assign dvalidB = o_vb;
        end else begin : g_no_out_reg
            assign doutA   = s1_a;
            assign doutB   = s1_b;
            assign dvalidA = s1_va;
            assign dvalidB = s1_vb;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            collision <= 1'b0;
            coll_cnt  <= '0;
        end else begin
            collision <= same_wr;
            if (same_wr && (coll_cnt != 16'hFFFF)) coll_cnt <= coll_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_ram_true_dp_param.sv
// tb/tb_ram_true_dp_param.sv - scoreboard bench for ram_true_dp_param across all three write modes
module tb_ram_true_dp_param;
    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        weA, weB, reA, reB;
    logic [3:0]  beA, beB, addrA, addrB;
    logic [31:0] dinA, dinB;

    logic [31:0] dout [6];
    logic        dv   [6];
    logic        coll [3];
    logic [15:0] ccnt [3];

    logic [31:0] mdl [16];
    exp_t        q [6][$];
    logic [31:0] last [6];
    logic        hand_on [6];
    logic [31:0] hand_val [6];
    logic        p_coll = 1'b0;
    logic [15:0] m_cnt = '0;
    logic        exp_coll = 1'b0;
    logic [15:0] exp_cnt = '0;
    logic        armed = 1'b0;
    logic        rst_q = 1'b0;
    logic        done = 1'b0;
    logic        mon_ev;
    int          cyc = 0;
    int          checks = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    // Instance 0: write-first, 1: read-first, 2: no-change with output register.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [31:0] da, db;
        logic        va, vb, c;
        logic [15:0] cc;
        ram_true_dp_param #(
            .DATA_W(32), .ADDR_W(4), .WRITE_MODE(g), .OUT_REG((g == 2) ? 1 : 0)
        ) u_dut (
            .clk(clk), .rst(rst), .weA(weA), .weB(weB), .reA(reA), .reB(reB),
            .beA(beA), .beB(beB), .addrA(addrA), .addrB(addrB), .dinA(dinA), .dinB(dinB),
            .doutA(da), .doutB(db), .dvalidA(va), .dvalidB(vb), .collision(c), .coll_cnt(cc)
        );
        assign dout[2*g]   = da;
        assign dout[2*g+1] = db;
        assign dv[2*g]     = va;
        assign dv[2*g+1]   = vb;
        assign coll[g]     = c;
        assign ccnt[g]     = cc;
    end

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        exp_coll <= p_coll;
        exp_cnt  <= m_cnt;
        rst_q    <= rst;
        if (rst) armed <= 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            for (int ch = 0; ch < 6; ch++)
                check($sformatf("drained ch%0d", ch), 32'(q[ch].size()), 32'd0);
            $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
            $finish;
        end else if (armed) begin
            for (int ch = 0; ch < 6; ch++) begin
                if (rst_q) last[ch] = '0;
                while (q[ch].size() > 0 && q[ch][0].cyc < cyc) void'(q[ch].pop_front());
                mon_ev = (q[ch].size() > 0) && (q[ch][0].cyc == cyc);
                check($sformatf("dvalid ch%0d", ch), {31'b0, dv[ch]}, {31'b0, mon_ev});
                if (mon_ev) begin
                    check($sformatf("dout ch%0d", ch), dout[ch], q[ch][0].data);
                    last[ch] = q[ch][0].data;
                    void'(q[ch].pop_front());
                end else begin
                    check($sformatf("hold ch%0d", ch), dout[ch], last[ch]);
                end
            end
            for (int i = 0; i < 3; i++) begin
                check($sformatf("collision u%0d", i), {31'b0, coll[i]}, {31'b0, exp_coll});
                check($sformatf("coll_cnt u%0d", i), {16'b0, ccnt[i]}, {16'b0, exp_cnt});
            end
        end
    end

    function automatic void resp(input int mode, input logic w, input logic r,
                                 input logic [3:0] be, input logic [31:0] din,
                                 input logic [31:0] old, output logic v, output logic [31:0] d);
        logic [31:0] merged;
        merged = old;
        for (int k = 0; k < 4; k++)
            if (be[k]) merged[8*k +: 8] = din[8*k +: 8];
        v = 1'b0;
        d = old;
        if (w) begin
            if (mode == 0) begin v = 1'b1; d = merged; end
            else if (mode == 1) v = 1'b1;
        end else if (r) begin
            v = 1'b1;
        end
    endfunction

    task automatic push(input int ch, input int inst, input logic v, input logic [31:0] d);
        exp_t e;
        logic vv;
        vv     = v;
        e.data = d;
        if (hand_on[ch]) begin
            vv          = 1'b1;
            e.data      = hand_val[ch];
            hand_on[ch] = 1'b0;
        end
        e.cyc = cyc + 1 + ((inst == 2) ? 1 : 0);
        if (vv) q[ch].push_back(e);
    endtask

    task automatic hand(input int ch, input logic [31:0] val);
        hand_on[ch]  = 1'b1;
        hand_val[ch] = val;
    endtask

    task automatic drive(input logic r,
                         input logic wa, input logic ra, input logic [3:0] ba,
                         input logic [3:0] aa, input logic [31:0] da,
                         input logic wb, input logic rb, input logic [3:0] bb,
                         input logic [3:0] ab, input logic [31:0] db);
        logic [31:0] oa, ob, d;
        logic        v;
        @(negedge clk);
        #1;
        rst = r; weA = wa; reA = ra; beA = ba; addrA = aa; dinA = da;
        weB = wb; reB = rb; beB = bb; addrB = ab; dinB = db;
        if (r) begin
            for (int ch = 0; ch < 6; ch++) begin
                q[ch].delete();
                hand_on[ch] = 1'b0;
            end
            p_coll = 1'b0;
            m_cnt  = '0;
        end else begin
            oa = mdl[aa];
            ob = mdl[ab];
            for (int i = 0; i < 3; i++) begin
                resp(i, wa, ra, ba, da, oa, v, d);
                push(2*i, i, v, d);
                resp(i, wb, rb, bb, db, ob, v, d);
                push(2*i+1, i, v, d);
            end
            p_coll = wa && wb && (aa == ab);
            if (p_coll && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            // B lands first so A overwrites any lane both ports enable.
            for (int k = 0; k < 4; k++) if (wb && bb[k]) mdl[ab][8*k +: 8] = db[8*k +: 8];
            for (int k = 0; k < 4; k++) if (wa && ba[k]) mdl[aa][8*k +: 8] = da[8*k +: 8];
        end
    endtask

    task automatic idle(input logic r);
        drive(r, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    endtask

    initial begin
        rst = 1'b1; weA = 1'b0; weB = 1'b0; reA = 1'b0; reB = 1'b0;
        beA = '0; beB = '0; addrA = '0; addrB = '0; dinA = '0; dinB = '0;
        for (int ch = 0; ch < 6; ch++) begin
            hand_on[ch] = 1'b0; hand_val[ch] = '0; last[ch] = '0;
        end
        for (int a = 0; a < 16; a++) mdl[a] = '0;
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);

        for (int a = 0; a < 16; a += 2)
            drive(1'b0, 1'b1, 1'b0, 4'hF, 4'(a), $urandom, 1'b1, 1'b0, 4'hF, 4'(a + 1), $urandom);

        hand(0, 32'hDEADBEEF);
        drive(1'b0, 1'b1, 1'b0, 4'hF, 4'd5, 32'hDEADBEEF, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);

        drive(1'b0, 1'b1, 1'b0, 4'hF, 4'd5, 32'h11223344, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        hand(2, 32'h11223344);
        hand(0, 32'h1122CCDD);
        drive(1'b0, 1'b1, 1'b0, 4'b0011, 4'd5, 32'hAABBCCDD, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        hand(0, 32'h1122CCDD); hand(2, 32'h1122CCDD); hand(4, 32'h1122CCDD);
        drive(1'b0, 1'b0, 1'b1, 4'h0, 4'd5, 32'h0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);

        drive(1'b0, 1'b1, 1'b0, 4'b0001, 4'd7, 32'h000000AA, 1'b1, 1'b0, 4'hF, 4'd7, 32'h12345678);
        hand(1, 32'h123456AA); hand(3, 32'h123456AA); hand(5, 32'h123456AA);
        drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b1, 4'h0, 4'd7, 32'h0);

        drive(1'b0, 1'b1, 1'b0, 4'hF, 4'd9, 32'hCAFE0001, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        hand(1, 32'hCAFE0001); hand(3, 32'hCAFE0001); hand(5, 32'hCAFE0001);
        drive(1'b0, 1'b1, 1'b0, 4'hF, 4'd9, 32'h0, 1'b0, 1'b1, 4'h0, 4'd9, 32'h0);

        // Read in flight in the output register, then reset on the next edge.
        drive(1'b0, 1'b0, 1'b1, 4'h0, 4'd5, 32'h0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        idle(1'b1);
        idle(1'b0);
        hand(0, 32'h1122CCDD); hand(2, 32'h1122CCDD); hand(4, 32'h1122CCDD);
        drive(1'b0, 1'b0, 1'b1, 4'h0, 4'd5, 32'h0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);

        drive(1'b0, 1'b1, 1'b0, 4'hF, 4'd0, 32'h01020304, 1'b1, 1'b0, 4'hF, 4'd15, 32'hF0E0D0C0);
        hand(0, 32'hF0E0D0C0); hand(2, 32'hF0E0D0C0); hand(4, 32'hF0E0D0C0);
        hand(1, 32'h01020304); hand(3, 32'h01020304); hand(5, 32'h01020304);
        drive(1'b0, 1'b0, 1'b1, 4'h0, 4'd15, 32'h0, 1'b0, 1'b1, 4'h0, 4'd0, 32'h0);
        idle(1'b0);
        idle(1'b0);

        for (int n = 0; n < 2000; n++)
            drive(1'($urandom_range(0, 63) == 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
                  4'($urandom), $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
                  4'($urandom), $urandom);

        while (m_cnt != 16'hFFFF)
            drive(1'b0, 1'b1, 1'b1, 4'h0, 4'd3, 32'h0, 1'b1, 1'b1, 4'h0, 4'd3, 32'h0);
        for (int n = 0; n < 4; n++)
            drive(1'b0, 1'b1, 1'b1, 4'h0, 4'd3, 32'h0, 1'b1, 1'b1, 4'h0, 4'd3, 32'h0);

        idle(1'b0);
        idle(1'b0);
        idle(1'b0);
        done = 1'b1;
    end
endmodule
